// File: rtl/sd_otf_converter.sv
// Radix-2 signed-digit to two's-complement on-the-fly converter.
// It takes one digit per accepted cycle, most-significant digit first. Q and QM = Q-1 replace a carry-propagate adder.
module sd_otf_converter #(
    parameter int unrolling = 64
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 digit_valid,
    input  logic [1:0]           digit_in,
    output logic [unrolling:0]   q_out,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int CNT_W = $clog2(unrolling + 1);
    localparam int W     = unrolling + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(unrolling - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CONV = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_qm;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [W-1:0]       r_q_out;

    state_t             w_state_nxt;
    logic [W-1:0]       w_q_nxt;
    logic [W-1:0]       w_qm_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_err_nxt;
    logic               w_load_out;
    logic [W-1:0]       w_q_dig;
    logic [W-1:0]       w_qm_dig;
    logic               w_bad_dig;

    // Digit append: each digit picks either Q or QM as the prefix, so no carry chain is needed.
    always_comb begin
        w_q_dig   = {r_q[W-2:0], 1'b0};
        w_qm_dig  = {r_qm[W-2:0], 1'b1};
        w_bad_dig = 1'b0;
        case (digit_in)
            2'b10: begin
                w_q_dig  = {r_q[W-2:0], 1'b1};
                w_qm_dig = {r_q[W-2:0], 1'b0};
            end
            2'b01: begin
                w_q_dig  = {r_qm[W-2:0], 1'b1};
                w_qm_dig = {r_qm[W-2:0], 1'b0};
            end
            2'b00: begin
                w_q_dig  = {r_q[W-2:0], 1'b0};
                w_qm_dig = {r_qm[W-2:0], 1'b1};
            end
            default: begin
                w_q_dig   = {r_q[W-2:0], 1'b0};
                w_qm_dig  = {r_qm[W-2:0], 1'b1};
                w_bad_dig = 1'b1;
            end
        endcase
    end

    // Next-state and datapath update selection.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_qm_nxt    = r_qm;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CONV;
                    w_q_nxt     = {W{1'b0}};
                    w_qm_nxt    = {W{1'b1}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                if (start) begin
                    w_state_nxt = S_CONV;
                    w_q_nxt     = {W{1'b0}};
                    w_qm_nxt    = {W{1'b1}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_err_nxt   = 1'b0;
                end else if (digit_valid) begin
                    w_q_nxt   = w_q_dig;
                    w_qm_nxt  = w_qm_dig;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_err_nxt = r_err | w_bad_dig;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_DONE;
                        w_load_out  = 1'b1;
                    end else begin
                        w_state_nxt = S_CONV;
                    end
                end else begin
                    w_state_nxt = S_CONV;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CONV;
                    w_q_nxt     = {W{1'b0}};
                    w_qm_nxt    = {W{1'b1}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; a low enable freezes the controller.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state <= S_IDLE;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    // Conversion registers and the result, which loads only on the final digit.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_q     <= {W{1'b0}};
            r_qm    <= {W{1'b1}};
            r_cnt   <= {CNT_W{1'b0}};
            r_err   <= 1'b0;
            r_q_out <= {W{1'b0}};
        end else if (enable) begin
            r_q   <= w_q_nxt;
            r_qm  <= w_qm_nxt;
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
            if (w_load_out) begin
                r_q_out <= w_q_nxt;
            end
        end
    end

    // done is gated by enable, so a stalled DONE cycle shows no pulse.
    assign done  = (r_state == S_DONE) && enable;
    assign busy  = (r_state == S_CONV);
    assign err   = r_err;
    assign q_out = r_q_out;

endmodule

// File: tb/tb_sd_otf_converter.sv
// Directed, table-driven bench for sd_otf_converter with unrolling=4.
module tb_sd_otf_converter;

    localparam int U = 4;
    localparam logic [1:0] DP = 2'b10;
    localparam logic [1:0] DM = 2'b01;
    localparam logic [1:0] DZ = 2'b00;
    localparam logic [1:0] DX = 2'b11;

    typedef struct {
        logic       en;
        logic       st;
        logic       dv;
        logic [1:0] d;
        logic       e_done;
        logic       e_busy;
        logic [U:0] e_q;
        logic       e_err;
    } row_t;

    logic         clk;
    logic         asyn_reset;
    logic         enable;
    logic         start;
    logic         digit_valid;
    logic [1:0]   digit_in;
    logic [U:0]   q_out;
    logic         done;
    logic         busy;
    logic         err;

    int n_checks;
    int n_fail;
    row_t tbl[$];

    sd_otf_converter #(.unrolling(U)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .enable     (enable),
        .start      (start),
        .digit_valid(digit_valid),
        .digit_in   (digit_in),
        .q_out      (q_out),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic st, input logic dv, input logic [1:0] d,
                       input logic ed, input logic eb, input logic [U:0] eq, input logic ee);
        row_t r;
        r.en = en; r.st = st; r.dv = dv; r.d = d;
        r.e_done = ed; r.e_busy = eb; r.e_q = eq; r.e_err = ee;
        tbl.push_back(r);
    endtask

    // Drive a row just after a rising edge, check at the falling edge, then clock it in.
    task automatic run_row(input row_t r, input int idx);
        enable      = r.en;
        start       = r.st;
        digit_valid = r.dv;
        digit_in    = r.d;
        @(negedge clk);
        chk("done", idx, {31'd0, done}, {31'd0, r.e_done});
        chk("busy", idx, {31'd0, busy}, {31'd0, r.e_busy});
        chk("q_out", idx, {27'd0, q_out}, {27'd0, r.e_q});
        chk("err", idx, {31'd0, err}, {31'd0, r.e_err});
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], base + i);
        end
        tbl.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        asyn_reset  = 1'b1;
        enable      = 1'b0;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 2'b00;
        #2;
        chk("rst_q_out", 0, {27'd0, q_out}, 32'd0);
        chk("rst_done", 0, {31'd0, done}, 32'd0);
        chk("rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("rst_err", 0, {31'd0, err}, 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back +1,0,-1,+1 gives 7; a digit in IDLE is ignored.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b0, 5'd7, 1'b0);
        // Four -1 digits with a three-cycle gap give 5'b10001.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'b10001, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'b10001, 1'b0);
        // All +1 gives 15. A start in DONE still pulses done; all zeros then give 0.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'b10001, 1'b0);
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'b10001, 1'b0);
        add(1'b1, 1'b1, 1'b1, DP, 1'b1, 1'b0, 5'd15, 1'b0);
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd15, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd0, 1'b0);
        // An invalid digit acts as 0 and sets a sticky err.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DX, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd0, 1'b1);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd0, 1'b1);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'd7, 1'b1);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd7, 1'b1);
        run_table(1);

        // Abort mid-conversion. The digit in the restart cycle is discarded.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd7, 1'b1);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b1, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd7, 1'b0);
        // Stall mid-stream and in DONE. The digits +1,+1,0,-1 give 11.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b0, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b0, 1'b1, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd7, 1'b0);
        add(1'b0, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd11, 1'b0);
        add(1'b0, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd11, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'd11, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'd11, 1'b0);
        // Reach CONV with err set, ready for the reset sequence.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd11, 1'b0);
        add(1'b1, 1'b0, 1'b1, DP, 1'b0, 1'b1, 5'd11, 1'b0);
        add(1'b1, 1'b0, 1'b1, DX, 1'b0, 1'b1, 5'd11, 1'b0);
        run_table(100);

        // Asynchronous reset between clock edges clears outputs at once.
        enable      = 1'b1;
        start       = 1'b0;
        digit_valid = 1'b1;
        digit_in    = DP;
        #1;
        chk("pre_rst_err", 200, {31'd0, err}, 32'd1);
        chk("pre_rst_busy", 200, {31'd0, busy}, 32'd1);
        #2;
        asyn_reset = 1'b1;
        #1;
        chk("arst_q_out", 201, {27'd0, q_out}, 32'd0);
        chk("arst_busy", 201, {31'd0, busy}, 32'd0);
        chk("arst_err", 201, {31'd0, err}, 32'd0);
        chk("arst_done", 201, {31'd0, done}, 32'd0);
        #2;
        asyn_reset = 1'b0;
        @(posedge clk);
        #1;
        // Fresh conversion after reset: -1,0,0,0 gives 5'b11000.
        add(1'b1, 1'b1, 1'b0, DZ, 1'b0, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, DM, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b1, DZ, 1'b0, 1'b1, 5'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b1, 1'b0, 5'b11000, 1'b0);
        add(1'b1, 1'b0, 1'b0, DZ, 1'b0, 1'b0, 5'b11000, 1'b0);
        run_table(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
